// File: rtl/param_fifo_pkg.sv
// Shared defaults and the error-flag bundle for the param_fifo block.
package param_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;

    typedef struct packed {
        logic overflow;
        logic underflow;
        logic overrun;
        logic underrun;
    } fifo_err_t;

endpackage

// File: rtl/param_fifo_if.sv
// Request/response bundle between a FIFO user (master) and the FIFO itself (slave).
interface param_fifo_if
    import param_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              write_enable;
    logic              read_enable;
    logic [DATA_W-1:0] data_in;
    logic              clr_err;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;
    logic              overrun;
    logic              underrun;

    modport master (
        output write_enable, read_enable, data_in, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow, overrun, underrun
    );

    modport slave (
        input  write_enable, read_enable, data_in, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count,
               overflow, underflow, overrun, underrun
    );

endinterface

// File: rtl/param_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, contents never reset.
module param_fifo_mem #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO control with registered status and sticky errors.
// Define PARAM_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle read latency.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input logic       clk,
    input logic       rst,
    param_fifo_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfC    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AeC    = CW'(AE_THRESH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, empty_q, afull_q, aempty_q;
    fifo_err_t         err_q, err_d;
    logic              rd_acc, wr_acc;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        rd_acc   = bus.read_enable && !empty_q;
        // A full FIFO still takes a write when the same cycle frees a slot.
        wr_acc   = bus.write_enable && (!full_q || rd_acc);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        err_d.overflow  = bus.write_enable && !wr_acc;
        err_d.underflow = bus.read_enable && !rd_acc;
        // A new error beats clr_err in the same cycle.
        err_d.overrun   = err_d.overflow || (err_q.overrun && !bus.clr_err);
        err_d.underrun  = err_d.underflow || (err_q.underrun && !bus.clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == DepthC);
            empty_q  <= (count_d == '0);
            afull_q  <= (count_d >= AfC);
            aempty_q <= (count_d <= AeC);
            err_q    <= err_d;
        end
    end

    param_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (wr_acc && !rst),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (bus.data_in),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rdata)
    );

`ifdef PARAM_FIFO_FWFT_EN
    assign bus.data_out = empty_q ? '0 : rdata;
`else
    logic [DATA_W-1:0] dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= rdata;
        end
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = err_q.overflow;
    assign bus.underflow    = err_q.underflow;
    assign bus.overrun      = err_q.overrun;
    assign bus.underrun     = err_q.underrun;

endmodule
